// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-line bundle for serial_pattern_tx.
// The master side requests frames and the slave side (the transmitter) drives the line.
`timescale 1ns/1ps
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Din;
    logic             Ready;
    logic             Done;
    logic             Out1;

    modport master (output Start, output Din, input Ready, input Done, input Out1);
    modport slave  (input Start, input Din, output Ready, output Done, output Out1);
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter for the sequence-detector link.
// Line format: idle 0, preamble 1,0, data MSB first, optional even parity, stop 1.
//
// state | meaning
// IDLE  | line low, Ready high, waiting for Start
// PRE1  | preamble high bit
// PRE0  | preamble low bit
// DATA  | shifting out captured word, MSB first
// PAR   | even-parity bit (PARITY_EN only)
// STOP  | stop bit, then IDLE with a one-clock Done
`timescale 1ns/1ps
module serial_pattern_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic                CLK,
    input  logic                RST,
    serial_pattern_tx_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE1 = 3'd1,
        PRE0 = 3'd2,
        DATA = 3'd3,
        PAR  = 3'd4,
        STOP = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             par_q, par_d;
    logic             done_q, done_d;
    logic             out1_q, out1_d;
    logic             period_end;

    assign period_end = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            out1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            done_q  <= done_d;
            out1_q  <= out1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = PRE1;
                    sh_d    = bus.Din;
                    par_d   = ^bus.Din;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            PRE1: begin
                if (period_end) begin
                    state_d = PRE0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRE0: begin
                if (period_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PAR : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAR: begin
                if (period_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (period_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line value is decoded from the next state so Out1 is a flop aligned with the state it belongs to.
    always_comb begin
        out1_d = 1'b0;
        case (state_d)
            PRE1, STOP: out1_d = 1'b1;
            DATA:       out1_d = sh_d[WIDTH-1];
            PAR:        out1_d = par_d;
            default:    out1_d = 1'b0;
        endcase
    end

    assign bus.Ready = (state_q == IDLE);
    assign bus.Done  = done_q;
    assign bus.Out1  = out1_q;
endmodule
